// File: rtl/subbytes_engine.sv
// rtl/subbytes_engine.sv - AES SubBytes/InvSubBytes engine for one 128-bit state, LANES bytes per cycle
// Optional macro SUBBYTES_SELFCHECK_EN adds a per-lane reverse S-box check and a sticky err port.

module aes_gf_inv (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] b;
    p = 8'h00;
    b = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  assign y_o = gf_inv(a_i);
endmodule

module aes_sbox_fwd (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] t;

  aes_gf_inv u_inv (.a_i(a_i), .y_o(t));

  assign y_o = t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
endmodule

module aes_sbox_inv (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] t;

  assign t = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;

  aes_gf_inv u_inv (.a_i(t), .y_o(y_o));
endmodule

module subbytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
`ifdef SUBBYTES_SELFCHECK_EN
  ,
  output logic         err
`endif
);
  localparam int ITER = 16 / LANES;
  localparam int CW   = $clog2(ITER) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_e;

  fsm_e           fsm_q, fsm_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   out_q, out_d;

  logic [7:0] lane_in  [LANES];
  logic [7:0] fwd_out  [LANES];
  logic [7:0] inv_out  [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = data_q[(int'(cnt_q) * LANES + l) * 8 +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_fwd u_fwd (.a_i(lane_in[g]), .y_o(fwd_out[g]));
    aes_sbox_inv u_inv (.a_i(lane_in[g]), .y_o(inv_out[g]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid) fsm_d = RUN;
      RUN:     if (cnt_q == LAST) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_q)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Result is latched into out_q on the last RUN cycle so it survives the next block's RUN
  always_comb begin
    data_d = data_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          mode_d = in_mode;
          cnt_d  = '0;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          data_d[(int'(cnt_q) * LANES + l) * 8 +: 8] = mode_q ? inv_out[l] : fwd_out[l];
        end
        if (cnt_q == LAST) begin
          cnt_d = '0;
          out_d = data_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      data_q <= '0;
      out_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      data_q <= data_d;
      out_q  <= out_d;
    end
  end

  assign out_data = out_q;

`ifdef SUBBYTES_SELFCHECK_EN
  logic [7:0]       fwd_back [LANES];
  logic [7:0]       inv_back [LANES];
  logic [LANES-1:0] lane_bad;
  logic             err_q;

  for (genvar g = 0; g < LANES; g++) begin : g_chk
    aes_sbox_inv u_chk_inv (.a_i(fwd_out[g]), .y_o(fwd_back[g]));
    aes_sbox_fwd u_chk_fwd (.a_i(inv_out[g]), .y_o(inv_back[g]));
    assign lane_bad[g] = mode_q ? (inv_back[g] != lane_in[g]) : (fwd_back[g] != lane_in[g]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err_q <= 1'b0;
    else if (fsm_q == RUN && |lane_bad)   err_q <= 1'b1;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_subbytes_engine.sv
// tb/tb_subbytes_engine.sv - directed vector bench for subbytes_engine (LANES 4, plus 1 and 16 sweep)

module tb_subbytes_engine;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_mode, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;
  logic         vs, rs, rdy1, rdy16, ov1, ov16, busy1, busy16;
  logic [127:0] ds, od1, od16;
`ifdef SUBBYTES_SELFCHECK_EN
  logic         err, err1, err16;
`endif

  localparam logic [127:0] ORD   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ORD_S = 128'h637c777bf26b6fc53001672bfed7ab76;

  typedef struct {
    logic         mode;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  subbytes_engine #(.LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef SUBBYTES_SELFCHECK_EN
    , .err(err)
`endif
  );

  subbytes_engine #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vs), .in_ready(rdy1), .in_mode(1'b0),
    .in_data(ds), .out_valid(ov1), .out_ready(rs), .out_data(od1), .busy(busy1)
`ifdef SUBBYTES_SELFCHECK_EN
    , .err(err1)
`endif
  );

  subbytes_engine #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(vs), .in_ready(rdy16), .in_mode(1'b0),
    .in_data(ds), .out_valid(ov16), .out_ready(rs), .out_data(od16), .busy(busy16)
`ifdef SUBBYTES_SELFCHECK_EN
    , .err(err16)
`endif
  );

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Accept one block on the LANES=4 instance, check latency, result and the out handshake
  task automatic run4(input string nm, input logic m, input logic [127:0] d, input logic [127:0] e);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    check({nm, " in_ready idle"}, 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mode  = ~m;
    in_data  = ~d;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
    check({nm, " latency"}, 128'(lat), 128'd4);
    check({nm, " out_data"}, out_data, e);
    check({nm, " busy done"}, 128'(busy), 128'd1);
    check({nm, " in_ready done"}, 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({nm, " out_valid drop"}, 128'(out_valid), 128'd0);
    check({nm, " out_data held"}, out_data, e);
  endtask

  initial begin
    vec_t tbl[7];
    logic [127:0] held;
    int lat1, lat16, c;

    tbl[0] = '{1'b0, 128'h0,           {16{8'h63}}};
    tbl[1] = '{1'b0, ORD,              ORD_S};
    tbl[2] = '{1'b1, ORD_S,            ORD};
    tbl[3] = '{1'b1, 128'h0,           {16{8'h52}}};
    tbl[4] = '{1'b0, {16{8'hff}},      {16{8'h16}}};
    tbl[5] = '{1'b0, {16{8'h53}},      {16{8'hed}}};
    tbl[6] = '{1'b1, {16{8'hed}},      {16{8'h53}}};

    rst_n = 1'b0;
    in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    vs = 1'b0; rs = 1'b0; ds = '0;
    #12;
    check("reset in_ready", 128'(in_ready), 128'd1);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset out_data", out_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run4($sformatf("vec%0d", i), tbl[i].mode, tbl[i].din, tbl[i].dout);
    end

    // Backpressure: stall in DONE with a second block waiting
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b0; in_data = ORD;
    @(posedge clk);
    #1;
    in_data = {16{8'hff}};
    repeat (4) @(posedge clk);
    #1;
    check("bp out_valid", 128'(out_valid), 128'd1);
    held = out_data;
    check("bp first result", held, ORD_S);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp stall%0d data", i), out_data, held);
      check($sformatf("bp stall%0d valid", i), 128'(out_valid), 128'd1);
      check($sformatf("bp stall%0d in_ready", i), 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp after hs out_valid", 128'(out_valid), 128'd0);
    check("bp after hs in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp second accepted", 128'(busy), 128'd1);
    repeat (4) @(posedge clk);
    #1;
    check("bp second valid", 128'(out_valid), 128'd1);
    check("bp second data", out_data, {16{8'h16}});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset on the second RUN cycle
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b1; in_data = ORD_S;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 128'(out_valid), 128'd0);
    check("rst in_ready", 128'(in_ready), 128'd1);
    check("rst busy", 128'(busy), 128'd0);
    check("rst out_data", out_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run4("post rst", 1'b0, 128'h0, {16{8'h63}});

    // LANES 1 and 16 on the ordering vector
    @(negedge clk);
    vs = 1'b1; ds = ORD;
    check("sweep rdy1", 128'(rdy1), 128'd1);
    check("sweep rdy16", 128'(rdy16), 128'd1);
    @(posedge clk);
    #1;
    vs = 1'b0; ds = '0;
    lat1 = 0; lat16 = 0; c = 0;
    while (lat1 == 0 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if (ov16 && lat16 == 0) lat16 = c;
      if (ov1 && lat1 == 0) lat1 = c;
    end
    check("sweep lat1", 128'(lat1), 128'd16);
    check("sweep lat16", 128'(lat16), 128'd1);
    check("sweep data1", od1, ORD_S);
    check("sweep data16", od16, ORD_S);
    check("sweep ov16 held", 128'(ov16), 128'd1);
    rs = 1'b1;
    @(posedge clk);
    #1;
    rs = 1'b0;
    check("sweep ov1 drop", 128'(ov1), 128'd0);
    check("sweep ov16 drop", 128'(ov16), 128'd0);

`ifdef SUBBYTES_SELFCHECK_EN
    check("err lanes4", 128'(err), 128'd0);
    check("err lanes1", 128'(err1), 128'd0);
    check("err lanes16", 128'(err16), 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
